// File: rtl/alu_ctrl_seq_if.sv
// Decode-to-ALU-control handshake bundle: instruction in, registered ALU operation out.
interface alu_ctrl_seq_if #(
   parameter int OP_W = 5,
   parameter int FN_W = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] opcode;
   logic [FN_W-1:0] funct;
   logic            flush;
   logic            op_valid;
   logic [FN_W-1:0] operation;
   logic            op_multi;
   logic            op_last;
   logic            illegal;

   modport master (
      output in_valid, opcode, funct, flush,
      input  in_ready, op_valid, operation, op_multi, op_last, illegal
   );

   modport slave (
      input  in_valid, opcode, funct, flush,
      output in_ready, op_valid, operation, op_multi, op_last, illegal
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decoder with valid/ready issue and multi-cycle op sequencing.
// Optional illegal-opcode trap enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_seq #(
   parameter int              OP_W       = 5,
   parameter int              FN_W       = 5,
   parameter logic [OP_W-1:0] OPC_ART    = OP_W'(0),
   parameter logic [OP_W-1:0] OPC_LOG    = OP_W'(1),
   parameter logic [OP_W-1:0] OPC_CRY    = OP_W'(2),
   parameter logic [OP_W-1:0] OPC_IMM    = OP_W'(3),
   parameter logic [FN_W-1:0] IMMED_CODE = FN_W'(31),
   parameter logic [FN_W-1:0] MC_FN_LO   = FN_W'(24),
   parameter logic [FN_W-1:0] MC_FN_HI   = FN_W'(30),
   parameter int              MC_LAT     = 4
) (
   input logic          clk,
   input logic          rst,
   alu_ctrl_seq_if.slave bus
);

   localparam logic [3:0] LAST = 4'(MC_LAT - 1);

   typedef enum logic [1:0] {IDLE, SINGLE, MULTI} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic            vld, multi, last, rdy, ill;
   logic [FN_W-1:0] op;

   logic [FN_W-1:0] dec_op;
   logic            dec_mc, known, unk, acc;
   logic [3:0]      cnt_nx;

   always_comb begin
      dec_op = '0;
      known  = 1'b1;
      if (bus.opcode == OPC_ART || bus.opcode == OPC_LOG || bus.opcode == OPC_CRY)
         dec_op = bus.funct;
      else if (bus.opcode == OPC_IMM)
         dec_op = IMMED_CODE;
      else
         known = 1'b0;
   end

   // An inverted window (LO > HI) can never match, so nothing goes multi-cycle.
   assign dec_mc = (bus.opcode == OPC_ART) && (bus.funct >= MC_FN_LO) && (bus.funct <= MC_FN_HI);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   assign unk = !known;
`else
   assign unk = 1'b0 & known;
`endif

   assign acc    = bus.in_valid && rdy;
   assign cnt_nx = cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         vld   <= 1'b0;
         op    <= '0;
         multi <= 1'b0;
         last  <= 1'b0;
         rdy   <= 1'b1;
         ill   <= 1'b0;
      end else if (bus.flush) begin
         state <= IDLE;
         cnt   <= '0;
         vld   <= 1'b0;
         multi <= 1'b0;
         last  <= 1'b0;
         rdy   <= 1'b1;
         ill   <= 1'b0;
      end else if (acc) begin
         // MC_LAT >= 2, so a multi-cycle op always blocks issue on its first cycle.
         state <= dec_mc ? MULTI : SINGLE;
         cnt   <= '0;
         vld   <= 1'b1;
         op    <= dec_op;
         multi <= dec_mc;
         last  <= !dec_mc;
         rdy   <= !dec_mc;
         ill   <= unk;
      end else if (state == MULTI && cnt != LAST) begin
         cnt  <= cnt_nx;
         last <= (cnt_nx == LAST);
         rdy  <= (cnt_nx == LAST);
      end else begin
         state <= IDLE;
         cnt   <= '0;
         vld   <= 1'b0;
         multi <= 1'b0;
         last  <= 1'b0;
         rdy   <= 1'b1;
         ill   <= 1'b0;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.op_valid  = vld;
   assign bus.operation = op;
   assign bus.op_multi  = multi;
   assign bus.op_last   = last;
   assign bus.illegal   = ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: per-instruction model pushes expected output cycles.
module tb_alu_ctrl_seq;
   localparam int MC_LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_seq_if #(.OP_W(5), .FN_W(5)) bus ();
   alu_ctrl_seq dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int         cyc;
      logic [4:0] op;
      bit         multi;
      bit         last;
      bit         ill;
   } exp_t;

   exp_t sbq[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_err  = 0;
   bit   mon_en = 1'b0;
   bit   m_rdy  = 1'b1;
   bit   m_acc  = 1'b0;
   int   blk    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [4:0] m_op(input logic [4:0] opc, input logic [4:0] fn);
      case (opc)
         5'd0, 5'd1, 5'd2: return fn;
         5'd3:             return 5'd31;
         default:          return 5'd0;
      endcase
   endfunction

   function automatic bit m_multi(input logic [4:0] opc, input logic [4:0] fn);
      return opc == 5'd0 && fn >= 5'd24 && fn <= 5'd30;
   endfunction

   function automatic bit m_ill(input logic [4:0] opc);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      return opc > 5'd3;
`else
      return opc > 5'd31;
`endif
   endfunction

   // Applies what happened at the edge just passed to the reference model.
   task automatic model_edge(input bit v, input logic [4:0] opc, input logic [4:0] fn,
                             input bit fl, input bit r);
      int len;
      bit mc;
      m_acc = v && m_rdy && !r && !fl;
      if (r || fl) begin
         while (sbq.size() > 0 && sbq[$].cyc >= cyc) void'(sbq.pop_back());
         blk = 0;
      end
      if (m_acc) begin
         mc  = m_multi(opc, fn);
         len = mc ? MC_LAT : 1;
         for (int i = 0; i < len; i++)
            sbq.push_back('{cyc + i, m_op(opc, fn), mc, i == len - 1, m_ill(opc)});
         blk = mc ? MC_LAT - 1 : 0;
      end else if (!(r || fl) && blk > 0) begin
         blk--;
      end
      m_rdy = (blk == 0);
      chk("in_ready", bus.in_ready, m_rdy);
   endtask

   task automatic step(input bit v, input logic [4:0] opc, input logic [4:0] fn,
                       input bit fl, input bit r);
      bus.in_valid = v;
      bus.opcode   = opc;
      bus.funct    = fn;
      bus.flush    = fl;
      rst          = r;
      @(posedge clk);
      #1;
      model_edge(v, opc, fn, fl, r);
   endtask

   task automatic issue(input logic [4:0] opc, input logic [4:0] fn);
      int tries = 0;
      do begin
         step(1'b1, opc, fn, 1'b0, 1'b0);
         tries++;
      end while (!m_acc && tries < 20);
      if (!m_acc) begin
         n_chk++;
         n_err++;
         $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      bit   ev;
      exp_t e;
      if (mon_en) begin
         ev = sbq.size() > 0 && sbq[0].cyc == cyc;
         chk("op_valid", bus.op_valid, ev);
         if (ev) begin
            e = sbq.pop_front();
            if (bus.op_valid === 1'b1) begin
               chk("operation", bus.operation, e.op);
               chk("op_multi", bus.op_multi, e.multi);
               chk("op_last", bus.op_last, e.last);
               chk("illegal", bus.illegal, e.ill);
            end
         end
      end
   end

   initial begin
      bit         cv;
      logic [4:0] co, cf;
      bit         fl, r;

      // Reset held with in_valid asserted.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 5'd1, 5'd6, 1'b0, 1'b1);
         mon_en = 1'b1;
         chk("rst_operation", bus.operation, 5'd0);
         chk("rst_illegal", bus.illegal, 1'b0);
      end

      // Back-to-back single-cycle stream.
      idle(1);
      step(1'b1, 5'd1, 5'd6, 1'b0, 1'b0);
      step(1'b1, 5'd3, 5'($urandom), 1'b0, 1'b0);
      step(1'b1, 5'd2, 5'd2, 1'b0, 1'b0);
      idle(2);

      // Multi-cycle op followed by a held follow-on.
      issue(5'd0, 5'd25);
      issue(5'd0, 5'd1);
      idle(2);

      // Multi-cycle window boundaries.
      issue(5'd0, 5'd23);
      issue(5'd0, 5'd24);
      issue(5'd0, 5'd30);
      issue(5'd0, 5'd31);
      issue(5'd1, 5'd25);
      idle(MC_LAT + 1);

      // Flush on the 2nd multi cycle, then flush against a concurrent accept.
      issue(5'd0, 5'd25);
      idle(1);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
      idle(1);
      step(1'b1, 5'd1, 5'd7, 1'b1, 1'b0);
      idle(1);

      // Reset on the 2nd multi cycle, then a full multi op.
      issue(5'd0, 5'd25);
      idle(1);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
      issue(5'd0, 5'd26);
      idle(MC_LAT + 1);

      // Unknown opcode.
      issue(5'd9, 5'd5);
      idle(2);

      // Randomized traffic; inputs held while a presented instruction stalls.
      cv = 1'b0; co = '0; cf = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!(cv && !m_rdy)) begin
            cv = ($urandom_range(0, 3) != 0);
            co = 5'($urandom_range(0, 5));
            if (co == 5'd5) co = 5'd9;
            cf = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(22, 31)) : 5'($urandom);
         end
         fl = ($urandom_range(0, 29) == 0);
         r  = ($urandom_range(0, 99) == 0);
         step(cv, co, cf, fl, r);
      end

      idle(MC_LAT + 2);
      chk("sb_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder in the 19-bit CPU.
- Maps opcode/funct to the ALU operation code and registers the result.
- Adds a valid/ready handshake toward decode.
- Sequences multi-cycle ALU operations (multiply/divide class) with a busy counter, stalling issue until the operation completes.
- Sits between instruction decode and the ALU/execute stage.

Parameters:
- OP_W, 5, opcode width
- FN_W, 5, funct width; also the width of the operation output
- OPC_ART, 5'd0, arithmetic opcode; operation = funct
- OPC_LOG, 5'd1, logical opcode; operation = funct
- OPC_CRY, 5'd2, carry-class opcode; operation = funct
- OPC_IMM, 5'd3, immediate opcode; operation = IMMED_CODE
- IMMED_CODE, 5'd31, ALU code driven for OPC_IMM
- MC_FN_LO, 5'd24, lowest funct (OPC_ART only) treated as multi-cycle
- MC_FN_HI, 5'd30, highest funct treated as multi-cycle (inclusive)
- MC_LAT, 4, cycles a multi-cycle operation occupies the ALU; legal range 2..15

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  block can accept this cycle
- opcode  input  OP_W  instruction opcode
- funct  input  FN_W  instruction funct field
- flush  input  1  synchronous kill of any in-flight operation
- op_valid  output  1  operation is valid for the ALU
- operation  output  FN_W  registered ALU operation code
- op_multi  output  1  current operation is multi-cycle
- op_last  output  1  final cycle of the current operation
- illegal  output  1  unknown opcode accepted (optional feature)

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high; it has priority over everything else.
  - Reset values: state=IDLE, cnt=0, op_valid=0, operation=0, op_multi=0, op_last=0, illegal=0.
  - in_ready is 1 from the first cycle after reset.
- Decode
  - OPC_ART/LOG/CRY give operation = funct.
  - OPC_IMM gives operation = IMMED_CODE.
  - Any other opcode gives operation = 0.
  - An operation is multi-cycle iff opcode==OPC_ART and MC_FN_LO <= funct <= MC_FN_HI (unsigned compare).
- Handshake
  - An instruction is accepted when in_valid && in_ready at a rising edge.
  - Latency is 1: decoded fields appear on the registered outputs the cycle after acceptance.
  - opcode and funct are sampled only on acceptance.
- State machine
  - States: IDLE, SINGLE, MULTI. cnt is 4 bits.
  - IDLE: in_ready=1. Accepting a single-cycle op goes to SINGLE; accepting a multi-cycle op goes to MULTI with cnt=0.
  - SINGLE: op_valid=1, op_last=1, op_multi=0 for exactly one cycle.
    - in_ready=1, so a back-to-back accept re-enters SINGLE or MULTI.
    - With no accept, the next state is IDLE and op_valid drops to 0.
  - MULTI: op_valid=1 and op_multi=1, with operation held constant. cnt increments each cycle.
    - op_last=1 when cnt==MC_LAT-1.
    - in_ready=0 while cnt<MC_LAT-1 and 1 on the last cycle, allowing a zero-bubble follow-on.
    - After the last cycle, the next state is IDLE, SINGLE or MULTI depending on the accept.
- Boundary conditions
  - flush asserted: next state IDLE, op_valid=0, op_multi=0, cnt=0.
    - A concurrent accept is discarded; in_ready is still driven normally that cycle.
  - rst asserted mid-MULTI: reset values apply next cycle; the counter does not resume.
  - in_valid held while in_ready=0: no accept and no state change. Decode must hold its inputs.
  - MC_FN_LO > MC_FN_HI: no operation is multi-cycle.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An accepted opcode outside ART/LOG/CRY/IMM registers illegal=1 for the op's single cycle, together with op_valid=1 and operation=0.
  - illegal clears on the next cycle, on flush, and on rst.
- Undefined:
  - illegal is tied to 0.
  - Unknown opcodes issue silently as operation 0 in SINGLE.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> op_valid=0, operation=0, illegal=0 throughout; in_ready=1 on the first cycle after release.
- Single-cycle stream: OPC_LOG/funct=5'd6, then OPC_IMM/any funct, then OPC_CRY/5'd2 on consecutive cycles -> operation 6, 31, 2 on consecutive cycles, op_valid=1 each, op_last=1 each, in_ready never low.
- Multi-cycle: OPC_ART/funct=5'd25 followed by OPC_ART/5'd1 held valid -> operation=25 with op_multi=1 for 4 cycles, op_last on the 4th, in_ready low for 3 cycles, operation=1 on the 5th cycle with no bubble.
- Boundaries: funct 5'd23, 5'd24, 5'd30, 5'd31 under OPC_ART -> op_multi 0, 1, 1, 0; OPC_LOG/5'd25 -> op_multi=0.
- Flush/reset: flush on the 2nd cycle of a multi-cycle op -> op_valid=0 next cycle, in_ready=1; repeat with rst instead -> identical outcome, and a new multi-cycle op afterwards runs the full 4 cycles.
- Illegal: opcode 5'd9 accepted -> with ALU_CTRL_ILLEGAL_TRAP_EN, illegal=1 and operation=0 for 1 cycle; without it, illegal=0 and operation=0.
